sha_job_server: RTL and testbench

SHA_JOB_SERVER -- requirements
Module: sha_job_server

---
 rtl/sha_job_server.sv | 199 +++++++++++++++++++
 tb/tb_sha_job_server.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_job_server.sv
// sha_job_server: job sequencer and shared memory between a host and a SHA-256 engine.
//
// The host loads the message into a DEPTH x 32 memory while idle and requests a job with job_go.
// The server pulses start to the engine, waits for the engine's done level to fall and then rise
// again, and streams the eight hash words (h0..h7) from OUT_BASE back to the host over a
// valid/ready channel. job_done pulses for one cycle once beat 7 has been accepted.
//
// Ports
//   clk, reset                     clock, asynchronous active-high reset
//   host_wr_en/host_addr/host_wdata host write port, honoured only while idle
//   job_go                         request one hash job (ignored unless idle)
//   busy, job_done                 job in progress, one-cycle completion pulse
//   hash_valid/hash_data/hash_ready result stream, h0 first
//   start, message_addr, output_addr engine control, addresses are constant
//   done                           engine idle level
//   mem_we/mem_addr/mem_write_data engine memory port, one-cycle read latency
//   mem_read_data                  read data back to the engine
//   wr_err                         engine wrote other than 8 words (only with SHA_WR_CHECK_EN)
//
// Configuration macro: SHA_WR_CHECK_EN adds the engine write counter and the wr_err port.

module sha_job_server #(
    parameter int unsigned DEPTH    = 64,
    parameter logic [15:0] MSG_BASE = 16'h0000,
    parameter logic [15:0] OUT_BASE = 16'h0020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        host_wr_en,
    input  logic [15:0] host_addr,
    input  logic [31:0] host_wdata,
    input  logic        job_go,
    output logic        busy,
    output logic        job_done,
    output logic        hash_valid,
    output logic [31:0] hash_data,
    input  logic        hash_ready,
    output logic        start,
    output logic [15:0] message_addr,
    output logic [15:0] output_addr,
    input  logic        done,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data
`ifdef SHA_WR_CHECK_EN
    ,
    output logic        wr_err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitBusy,
        StWaitDone,
        StCollect
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic        job_done_q, job_done_d;
    logic [31:0] rdata_q;
    logic [31:0] mem [DEPTH];

    logic [15:0]   out_addr;
    logic [AW-1:0] out_idx;
    logic [AW-1:0] eng_idx;
    logic [AW-1:0] host_idx;
    logic          engine_window;

    // Address arithmetic is 16-bit; only the low AW bits select a word.
    assign out_addr      = OUT_BASE + {13'd0, k_q};
    assign out_idx       = out_addr[AW-1:0];
    assign eng_idx       = mem_addr[AW-1:0];
    assign host_idx      = host_addr[AW-1:0];
    assign engine_window = (state_q == StWaitBusy) || (state_q == StWaitDone);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{host_addr[15:AW], mem_addr[15:AW], out_addr[15:AW]};

    assign message_addr  = MSG_BASE;
    assign output_addr   = OUT_BASE;
    assign busy          = (state_q != StIdle);
    assign job_done      = job_done_q;
    assign mem_read_data = rdata_q;

    // State, beat index and completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            k_q        <= 3'd0;
            job_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            job_done_q <= job_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        job_done_d = 1'b0;
        start      = 1'b0;
        hash_valid = 1'b0;
        hash_data  = 32'd0;
        unique case (state_q)
            StIdle: begin
                if (job_go) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                start   = 1'b1;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (!done) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (done) begin
                    state_d = StCollect;
                    k_d     = 3'd0;
                end
            end
            StCollect: begin
                // Memory cannot change in this state, so the beat is stable while stalled.
                hash_valid = 1'b1;
                hash_data  = mem[out_idx];
                if (hash_ready) begin
                    if (k_q == 3'd7) begin
                        state_d    = StIdle;
                        k_d        = 3'd0;
                        job_done_d = 1'b1;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Shared memory; deliberately not reset. Host and engine windows are mutually exclusive.
    always_ff @(posedge clk) begin
        if (host_wr_en && (state_q == StIdle)) begin
            mem[host_idx] <= host_wdata;
        end else if (mem_we && engine_window) begin
            mem[eng_idx] <= mem_write_data;
        end
    end

    // Engine read port: old data on a same-cycle write, every cycle regardless of mem_we.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= 32'd0;
        end else begin
            rdata_q <= mem[eng_idx];
        end
    end

`ifdef SHA_WR_CHECK_EN
    logic [3:0] wr_cnt_q, wr_cnt_d;
    logic       wr_err_q;

    // Saturating so an over-writing engine can never wrap back to exactly 8.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (mem_we && engine_window && (wr_cnt_q != 4'hf)) begin
            wr_cnt_d = wr_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt_q <= 4'd0;
            wr_err_q <= 1'b0;
        end else if (state_q == StStart) begin
            wr_cnt_q <= 4'd0;
            wr_err_q <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            if ((state_q == StWaitDone) && done) begin
                wr_err_q <= (wr_cnt_d != 4'd8);
            end
        end
    end

    assign wr_err = wr_err_q;
`endif

endmodule

// File: tb/tb_sha_job_server.sv
// Self-checking bench for sha_job_server: scripted engine stub, scoreboard of hash beats.
module tb_sha_job_server;

    localparam int unsigned DEPTH    = 64;
    localparam logic [15:0] MSG_BASE = 16'h0000;
    localparam logic [15:0] OUT_BASE = 16'h0020;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        host_wr_en = 1'b0;
    logic [15:0] host_addr = 16'd0;
    logic [31:0] host_wdata = 32'd0;
    logic        job_go = 1'b0;
    logic        busy;
    logic        job_done;
    logic        hash_valid;
    logic [31:0] hash_data;
    logic        hash_ready = 1'b0;
    logic        start;
    logic [15:0] message_addr;
    logic [15:0] output_addr;
    logic        done = 1'b1;
    logic        mem_we = 1'b0;
    logic [15:0] mem_addr = 16'd0;
    logic [31:0] mem_write_data = 32'd0;
    logic [31:0] mem_read_data;
`ifdef SHA_WR_CHECK_EN
    logic        wr_err;
`endif

    sha_job_server #(
        .DEPTH    (DEPTH),
        .MSG_BASE (MSG_BASE),
        .OUT_BASE (OUT_BASE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .host_wr_en     (host_wr_en),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .job_go         (job_go),
        .busy           (busy),
        .job_done       (job_done),
        .hash_valid     (hash_valid),
        .hash_data      (hash_data),
        .hash_ready     (hash_ready),
        .start          (start),
        .message_addr   (message_addr),
        .output_addr    (output_addr),
        .done           (done),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
`ifdef SHA_WR_CHECK_EN
        ,
        .wr_err         (wr_err)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mdl [DEPTH];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [15:0] addr, input logic [31:0] data);
        host_wr_en = 1'b1;
        host_addr  = addr;
        host_wdata = data;
        tick();
        host_wr_en = 1'b0;
        mdl[addr[5:0]] = data;
    endtask

    task automatic eng_read(input string tag, input logic [15:0] addr, input logic [31:0] exp);
        mem_we   = 1'b0;
        mem_addr = addr;
        tick();
        check(tag, mem_read_data, exp);
    endtask

    // One full job: engine performs nwr writes of seed+i to OUT_BASE+i.
    task automatic run_job(input int nwr, input logic [31:0] seed);
        logic [15:0] a;
        logic        v;
        logic        r;
        int          beats;
        job_go     = 1'b1;
        host_wr_en = 1'b1;
        host_addr  = 16'd20;
        host_wdata = seed ^ 32'h1111_1111;
        tick();
        mdl[20]    = seed ^ 32'h1111_1111;
        job_go     = 1'b0;
        host_wr_en = 1'b0;
        check("start_pulse", {31'd0, start}, 32'd1);
        check("busy_start", {31'd0, busy}, 32'd1);
        tick();
        check("start_once", {31'd0, start}, 32'd0);
        tick();
        check("busy_waitbusy", {31'd0, busy}, 32'd1);
        done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem_we     = 1'b0;
            host_wr_en = 1'b0;
            job_go     = 1'b0;
            if (i < nwr) begin
                a              = OUT_BASE + 16'(i);
                mem_we         = 1'b1;
                mem_addr       = a;
                mem_write_data = seed + 32'(i);
                mdl[a[5:0]]    = seed + 32'(i);
                exp_q.push_back(seed + 32'(i));
            end else if (i == 8) begin
                // Dropped: not idle. job_go here must be ignored too.
                host_wr_en = 1'b1;
                host_addr  = 16'd5;
                host_wdata = 32'hDEAD_BEEF;
                job_go     = 1'b1;
            end else if (i == 9) begin
                mem_addr = 16'h0003;
            end
            tick();
        end
        mem_we     = 1'b0;
        host_wr_en = 1'b0;
        job_go     = 1'b0;
        check("rd_in_job", mem_read_data, mdl[3]);
        check("busy_waitdone", {31'd0, busy}, 32'd1);
        check("no_valid_waitdone", {31'd0, hash_valid}, 32'd0);
        for (int i = nwr; i < 8; i++) begin
            a = OUT_BASE + 16'(i);
            exp_q.push_back(mdl[a[5:0]]);
        end
        done = 1'b1;
        tick();
        check("collect_entry", {31'd0, hash_valid}, 32'd1);
`ifdef SHA_WR_CHECK_EN
        check("wr_err", {31'd0, wr_err}, (nwr != 8) ? 32'd1 : 32'd0);
`endif
        beats = 0;
        r     = 1'b1;
        for (int c = 0; c < 40 && beats < 8; c++) begin
            v = hash_valid;
            if (v && exp_q.size() > 0) begin
                check($sformatf("beat%0d", beats), hash_data, exp_q[0]);
            end
            check("no_early_done", {31'd0, job_done}, 32'd0);
            hash_ready = r;
            tick();
            if (v && r) begin
                void'(exp_q.pop_front());
                beats++;
            end
            r = ~r;
        end
        hash_ready = 1'b0;
        check("beat_count", 32'(beats), 32'd8);
        check("job_done_pulse", {31'd0, job_done}, 32'd1);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("valid_idle", {31'd0, hash_valid}, 32'd0);
        tick();
        check("job_done_single", {31'd0, job_done}, 32'd0);
        check("not_restarted", {31'd0, busy}, 32'd0);
        eng_read("host_wr_with_go", 16'd20, mdl[20]);
        eng_read("host_wr_dropped", 16'd5, mdl[5]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [7:0]  ch;
        for (int i = 0; i < int'(DEPTH); i++) mdl[i] = 32'd0;

        // Reset state.
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_job_done", {31'd0, job_done}, 32'd0);
        check("rst_valid", {31'd0, hash_valid}, 32'd0);
        check("rst_hash_data", hash_data, 32'd0);
        check("rst_rdata", mem_read_data, 32'd0);
`ifdef SHA_WR_CHECK_EN
        check("rst_wr_err", {31'd0, wr_err}, 32'd0);
`endif
        check("msg_addr", {16'd0, message_addr}, {16'd0, MSG_BASE});
        check("out_addr", {16'd0, output_addr}, {16'd0, OUT_BASE});
        reset = 1'b0;
        tick();

        // Pre-clear output words so unwritten beats are well defined, then load "abcd..." text.
        for (int i = 0; i < 8; i++) host_write(OUT_BASE + 16'(i), 32'h0F0F_0000 + 32'(i));
        for (int i = 0; i < 20; i++) begin
            w = 32'd0;
            for (int j = 0; j < 4; j++) begin
                ch = 8'(97 + ((4 * i + j) % 26));
                w  = {w[23:0], ch};
            end
            host_write(MSG_BASE + 16'(i), w);
        end

        eng_read("rd_addr3", 16'h0003, mdl[3]);
        eng_read("rd_wrap43", 16'h0043, mdl[3]);
        eng_read("rd_addr0", 16'h0000, mdl[0]);

        run_job(8, 32'h0000_0000);
        run_job(7, 32'hA500_0000);

        // Reset in the middle of a job.
        job_go = 1'b1;
        tick();
        job_go = 1'b0;
        tick();
        tick();
        done     = 1'b0;
        mem_addr = 16'h0003;
        tick();
        tick();
        check("busy_before_rst", {31'd0, busy}, 32'd1);
        check("rdata_before_rst", mem_read_data, mdl[3]);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_start", {31'd0, start}, 32'd0);
        check("mid_rst_valid", {31'd0, hash_valid}, 32'd0);
        check("mid_rst_hash", hash_data, 32'd0);
        check("mid_rst_rdata", mem_read_data, 32'd0);
        check("mid_rst_done", {31'd0, job_done}, 32'd0);
`ifdef SHA_WR_CHECK_EN
        check("mid_rst_wr_err", {31'd0, wr_err}, 32'd0);
`endif
        tick();
        reset = 1'b0;
        done  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_no_done", {31'd0, job_done}, 32'd0);
            check("post_rst_idle", {31'd0, busy}, 32'd0);
        end
        eng_read("mem_kept_out0", OUT_BASE, mdl[OUT_BASE[5:0]]);
        eng_read("mem_kept_msg3", 16'h0003, mdl[3]);

        run_job(8, 32'h1234_5600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
